muldiv_arbiter: RTL and testbench
=================================

Name: muldiv_arbiter

Overview:
- Shares the single sequential multiply/divide unit between two requesters (req0, req1).
- Downstream, the unit's start/valid controller runs the datapath (load/add/shift/sel).
- This block grants access round-robin, latches the winner's operands, pulses unit_start, and waits for unit_valid with a timeout.
- It returns the result to the winner with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand width; result is 2*WIDTH.
- TIMEOUT, 40, maximum WAIT cycles before the transaction is aborted with an error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 request; operands held stable while asserted.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- sign0  input  1  requester 0 signed-operation flag.
- req1, a1, b1, sign1  input  1/WIDTH/WIDTH/1  same as above for requester 1.
- gnt0, gnt1  output  1  grant, one-hot or zero.
- done0, done1  output  1  one-cycle completion pulse to the owner.
- err  output  1  valid with done; 1 means timeout.
- result  output  2*WIDTH  registered result; valid with done.
- busy  output  1  high in any state other than IDLE.
- unit_start  output  1  start pulse to the unit.
- unit_a, unit_b  output  WIDTH  latched operands to the unit.
- unit_sign  output  1  latched sign flag to the unit.
- unit_valid  input  1  unit completion.
- unit_result  input  2*WIDTH  unit output.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - state to IDLE;
  - all outputs to 0, including gnt*, done*, err, result, busy, unit_start, unit_a, unit_b, unit_sign;
  - priority pointer to 0 (requester 0 preferred);
  - wait counter to 0.
- Reset mid-transaction aborts it. No done pulse is issued, and a late unit_valid is ignored.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from state only (Moore).
- IDLE:
  - No req: stay.
  - Exactly one req: grant it.
  - Both req: grant the requester selected by the pointer.
  - On grant, latch a/b/sign of the winner into unit_a/unit_b/unit_sign, set owner, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - unit_start=1, gnt[owner]=1.
  - Clear counter, go to WAIT.
- WAIT:
  - unit_start=0, gnt[owner]=1.
  - Each edge: if unit_valid=1, latch result<=unit_result, err<=0, go to RESP.
  - Else, if counter==TIMEOUT-1, latch result<=0, err<=1, go to RESP.
  - Else counter++.
- RESP (exactly 1 cycle):
  - done[owner]=1, gnt[owner]=1; result/err valid.
  - Next edge: pointer<=~owner, go to IDLE.
- unit_valid is ignored outside WAIT, including a valid arriving during ISSUE.
- result and err hold their value until the next RESP or reset.
- Minimum latency: req sampled at edge 0 → ISSUE; unit_valid sampled at edge 2 → done visible in cycle 3; back in IDLE at edge 3.
- Earliest next grant is at edge 4, so IDLE is always at least 1 cycle.
- If req drops while granted, the transaction still completes and done is still pulsed. The requester must tolerate this.
- If req is still high after RESP, it is a new request. It is subject to round robin, so the other requester wins if both are pending.
- Operand changes on a*/b*/sign* after the IDLE grant edge have no effect.
- Counter is ceil(log2(TIMEOUT)) bits and never wraps; it saturates at abort.

Test Plan:
- Single request: reset, req0=1, a0=8'd12, b0=8'd11, sign0=0; unit_valid at 3rd WAIT cycle with unit_result=16'd132.
  - Required: gnt0 high through RESP; unit_start is a single pulse; unit_a=12, unit_b=11; done0 one cycle with result=132, err=0; gnt1/done1 stay 0.
- Contention round robin: req0=req1=1 held continuously, four transactions.
  - Required: grant order 0,1,0,1; each done pulse goes to the matching owner.
- Timeout: req1=1, unit_valid never asserted.
  - Required: exactly TIMEOUT=40 WAIT cycles, then done1=1, err=1, result=0; next transaction with valid returns err=0.
- Spurious valid: unit_valid=1 during ISSUE and while in IDLE.
  - Required: ignored; RESP occurs only on valid sampled in WAIT.
- Reset mid-WAIT: pull reset low during WAIT, then pulse unit_valid after release.
  - Required: all outputs 0 immediately (asynchronous), no done pulse, pointer=0, state IDLE.
- Operand hold: change a0 to 8'd99 one cycle after grant.
  - Required: unit_a stays at the latched value for the whole transaction.

Source files
------------

// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter that shares one sequential multiply/divide unit between two requesters.
// Latches the winner's operands, starts the unit, waits for valid with a timeout, returns a done pulse.
//
// state | meaning
// IDLE  | no transaction; pick a winner when any request is pending
// ISSUE | operands latched; unit_start pulsed for one cycle
// WAIT  | waiting for unit_valid; abort with err after TIMEOUT cycles
// RESP  | result/err valid; done pulsed to the owner for one cycle
module muldiv_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               sign0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  input  logic               sign1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic               err,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               unit_start,
  output logic [WIDTH-1:0]   unit_a,
  output logic [WIDTH-1:0]   unit_b,
  output logic               unit_sign,
  input  logic               unit_valid,
  input  logic [2*WIDTH-1:0] unit_result
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic          owner;
  logic          ptr;
  logic [CW-1:0] cnt;
  logic          grant_any;
  logic          grant_sel;

  // With a single request pending the pointer is irrelevant; only a tie consults it.
  always_comb begin
    grant_any = req0 | req1;
    if (req0 && req1)
      grant_sel = ptr;
    else
      grant_sel = req1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      ptr       <= 1'b0;
      cnt       <= '0;
      unit_a    <= '0;
      unit_b    <= '0;
      unit_sign <= 1'b0;
      result    <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner     <= grant_sel;
            unit_a    <= grant_sel ? a1 : a0;
            unit_b    <= grant_sel ? b1 : b0;
            unit_sign <= grant_sel ? sign1 : sign0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (unit_valid) begin
            result <= unit_result;
            err    <= 1'b0;
            state  <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            // counter is left at its last value: it saturates rather than wraps
            result <= '0;
            err    <= 1'b1;
            state  <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          ptr   <= ~owner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign unit_start = (state == S_ISSUE);
  assign gnt0       = busy & ~owner;
  assign gnt1       = busy & owner;
  assign done0      = (state == S_RESP) & ~owner;
  assign done1      = (state == S_RESP) & owner;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Bench for muldiv_arbiter: vector table run through a done-pulse scoreboard,
// plus hand sequences for idle spurious valid and reset in the middle of WAIT.
module tb_muldiv_arbiter;
  localparam int W  = 8;
  localparam int TO = 40;

  logic           clk;
  logic           reset;
  logic           req0, req1, sign0, sign1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           gnt0, gnt1, done0, done1, err, busy, unit_start, unit_sign;
  logic [2*W-1:0] result;
  logic [W-1:0]   unit_a, unit_b;
  logic           unit_valid;
  logic [2*W-1:0] unit_result;

  muldiv_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .sign0(sign0),
    .req1(req1), .a1(a1), .b1(b1), .sign1(sign1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err(err), .result(result), .busy(busy),
    .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b), .unit_sign(unit_sign),
    .unit_valid(unit_valid), .unit_result(unit_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit r0; bit r1;
    logic [W-1:0] a0; logic [W-1:0] b0; bit s0;
    logic [W-1:0] a1; logic [W-1:0] b1; bit s1;
    int vd;    // WAIT cycle index at which valid is driven; -1 = never
    bit spur;  // drive a garbage valid during ISSUE
    bit chg;   // change a0 one cycle after grant
    bit own;   // expected owner
  } vec_t;

  typedef struct {
    bit own;
    logic [2*W-1:0] res;
    bit e;
  } exp_t;

  vec_t vecs [12];
  exp_t sb [$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input bit ok,
                       input longint unsigned act, input longint unsigned req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    logic signed [2*W-1:0] sa, sbv;
    if (s) begin
      sa  = {{W{a[W-1]}}, a};
      sbv = {{W{b[W-1]}}, b};
    end else begin
      sa  = {{W{1'b0}}, a};
      sbv = {{W{1'b0}}, b};
    end
    return $unsigned(sa * sbv);
  endfunction

  task automatic check_all_zero(input string name);
    logic [31:0] ctl;
    ctl = {24'd0, gnt0, gnt1, done0, done1, err, busy, unit_start, unit_sign};
    check({name, "_ctl"}, ctl == 32'd0, ctl, 0);
    check({name, "_result"}, result == '0, result, 0);
    check({name, "_unit_ab"}, {unit_a, unit_b} == '0, {unit_a, unit_b}, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e, got;
    logic [W-1:0] ea, eb;
    bit es, seen_done, gnt_ok, opnd_ok, first_start;
    int ncyc, nstart, nwait, exp_wait;
    req0 = v.r0; req1 = v.r1;
    a0 = v.a0; b0 = v.b0; sign0 = v.s0;
    a1 = v.a1; b1 = v.b1; sign1 = v.s1;
    unit_valid = 1'b0;
    ea = v.own ? v.a1 : v.a0;
    eb = v.own ? v.b1 : v.b0;
    es = v.own ? v.s1 : v.s0;
    e.own = v.own;
    e.e   = (v.vd < 0);
    e.res = e.e ? '0 : model(ea, eb, es);
    sb.push_back(e);
    exp_wait = (v.vd < 0) ? TO : v.vd + 1;
    seen_done = 0; gnt_ok = 1; opnd_ok = 1; first_start = 1;
    ncyc = 0; nstart = 0; nwait = 0;
    while (!seen_done && ncyc < 200) begin
      @(negedge clk);
      ncyc++;
      unit_valid = 1'b0;
      if (busy) begin
        if (gnt0 != !v.own || gnt1 != v.own) gnt_ok = 0;
        if (unit_a != ea || unit_b != eb || unit_sign != es) opnd_ok = 0;
      end else if (gnt0 || gnt1) begin
        gnt_ok = 0;
      end
      if (unit_start) begin
        nstart++;
        if (first_start) begin
          check({tag, "_issue_owner"}, gnt0 == !v.own && gnt1 == v.own, {gnt1, gnt0}, v.own ? 2 : 1);
          check({tag, "_issue_unit_a"}, unit_a == ea, unit_a, ea);
          first_start = 0;
        end
        if (v.spur) begin unit_valid = 1'b1; unit_result = 16'hDEAD; end
        if (v.chg) a0 = 8'd99;
      end else if (busy && !done0 && !done1) begin
        if (nwait == v.vd) begin unit_valid = 1'b1; unit_result = e.res; end
        nwait++;
      end
      if (done0 || done1) begin
        seen_done = 1;
        if (sb.size() == 0) begin
          check({tag, "_sb_empty"}, 0, 0, 1);
        end else begin
          got = sb.pop_front();
          check({tag, "_done_owner"}, done0 == !got.own && done1 == got.own, {done1, done0}, got.own ? 2 : 1);
          check({tag, "_result"}, result == got.res, result, got.res);
          check({tag, "_err"}, err == got.e, err, got.e);
        end
      end
    end
    unit_valid = 1'b0;
    check({tag, "_done_seen"}, seen_done, ncyc, 200);
    check({tag, "_start_pulses"}, nstart == 1, nstart, 1);
    check({tag, "_wait_cycles"}, nwait == exp_wait, nwait, exp_wait);
    check({tag, "_gnt_held"}, gnt_ok, 0, 1);
    check({tag, "_operands_held"}, opnd_ok, 0, 1);
    @(negedge clk);
    check({tag, "_back_idle"}, !done0 && !done1 && !busy, {done1, done0, busy}, 0);
    check({tag, "_result_hold"}, result == e.res, result, e.res);
  endtask

  initial begin
    vec_t v;
    int bad;
    bit got_start;
    vecs[0]  = '{1'b1, 1'b0, 8'd12,  8'd11,  1'b0, 8'd0,   8'd0,   1'b0,  2, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 8'd200, 8'd3,   1'b0,  0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 8'd7,   8'd9,   1'b0, 8'd15,  8'd15,  1'b0,  1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'd250, 8'd250, 1'b0, 8'hF0,  8'd3,   1'b1,  4, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'h80,  8'h80,  1'b1, 8'd2,   8'd2,   1'b0,  0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'd1,   8'd1,   1'b0, 8'd255, 8'd255, 1'b0,  5, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 8'd5,   8'd5,   1'b0, -1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'd0,   8'd0,   1'b0, 8'hFF,  8'd2,   1'b1,  1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 8'd10,  8'd10,  1'b0, 8'd0,   8'd0,   1'b0,  3, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'hFB,  8'd7,   1'b1, 8'd0,   8'd0,   1'b0,  2, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'd1,   8'd1,   1'b0, 8'd3,   8'd4,   1'b0,  0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 8'd2,   8'd3,   1'b0, 8'd0,   8'd0,   1'b0,  1, 1'b0, 1'b0, 1'b0};

    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; a0 = '0; b0 = '0; sign0 = 1'b0;
    a1 = '0; b1 = '0; sign1 = 1'b0;
    unit_valid = 1'b0; unit_result = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // valid while idle must not start or finish anything
    req0 = 1'b0; req1 = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      unit_valid = 1'b1; unit_result = 16'hBEEF;
      @(negedge clk);
      if (busy || done0 || done1 || unit_start) bad++;
    end
    unit_valid = 1'b0;
    check("idle_valid_quiet", bad == 0, bad, 0);
    check("idle_valid_result", result == 16'd6 && err == 1'b0, result, 6);

    // reset in WAIT with the pointer at 1
    req0 = 1'b1; a0 = 8'd33; b0 = 8'd44; sign0 = 1'b1;
    got_start = 0;
    for (int i = 0; i < 10 && !got_start; i++) begin
      @(negedge clk);
      if (unit_start) got_start = 1;
    end
    check("mid_issue", got_start, got_start, 1);
    @(negedge clk);
    check("mid_in_wait", busy && gnt0 && !unit_start, {busy, gnt0, unit_start}, 6);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b1; req0 = 1'b0;
    unit_valid = 1'b1; unit_result = 16'h1234;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) unit_valid = 1'b0;
      if (busy || done0 || done1 || result != '0 || err) bad++;
    end
    unit_valid = 1'b0;
    check("post_reset_quiet", bad == 0, bad, 0);
    v = '{1'b1, 1'b1, 8'd6, 8'd7, 1'b0, 8'd8, 8'd9, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    run_vec(v, "post_reset_ptr");

    check("sb_drained", sb.size() == 0, sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
